// File: rtl/soduku_solve_controller.sv
// soduku_solve_controller
//
// Sequences one solve of a sudoku board through an external solver datapath:
// latches the puzzle, holds the solver in reset for RESET_CYCLES cycles,
// lets it run, then captures the result on solver done or after
// TIMEOUT_CYCLES run cycles.
//
// State table
//   state | meaning
//   IDLE  | no run since reset; solver held in reset; waiting for start_in
//   LOAD  | puzzle presented; solver held in reset for RESET_CYCLES cycles
//   RUN   | solver released; counting cycles until done or timeout
//   DONE  | result captured and held; start_in begins a new run
//
// Ports
//   clk_in            single clock, rising edge
//   reset_n_in        asynchronous active-low reset
//   start_in          solve request (accepted in IDLE/DONE)
//   board_in          unsolved board, 4-bit cell per nibble, row 0/col 0 in MSBs
//   solver_reset_out  active-high reset to the solver datapath
//   solver_board_out  board presented to the solver (stable until next start)
//   solver_board_in   board produced by the solver
//   solver_done_in    solver completion flag
//   busy_out          high in LOAD and RUN
//   result_valid_out  one-cycle pulse on the first DONE cycle
//   solved_out        last run ended on done with no empty cell
//   timeout_out       last run ended by timeout
//   board_out         captured result board
//   cycles_out        RUN cycles consumed by the last run

module soduku_solve_controller #(
    parameter int GRID_SIZE      = 9,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                              clk_in,
    input  logic                              reset_n_in,
    input  logic                              start_in,
    input  logic [4*GRID_SIZE*GRID_SIZE-1:0]  board_in,
    output logic                              solver_reset_out,
    output logic [4*GRID_SIZE*GRID_SIZE-1:0]  solver_board_out,
    input  logic [4*GRID_SIZE*GRID_SIZE-1:0]  solver_board_in,
    input  logic                              solver_done_in,
    output logic                              busy_out,
    output logic                              result_valid_out,
    output logic                              solved_out,
    output logic                              timeout_out,
    output logic [4*GRID_SIZE*GRID_SIZE-1:0]  board_out,
    output logic [COUNT_WIDTH-1:0]            cycles_out
);

    localparam int CELLS = GRID_SIZE * GRID_SIZE;
    localparam int BW    = 4 * CELLS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [3:0]             load_cnt;
    logic [COUNT_WIDTH-1:0] cycle_cnt;
    logic                   start_ok;
    logic                   load_tc;
    logic                   done_seen;
    logic                   timeout_hit;
    logic                   finish;
    logic                   all_nz;

    // A done left over from the previous run is ignored on RUN cycle 0,
    // which is the only RUN cycle where the saturating counter reads zero.
    always_comb begin
        start_ok    = start_in && (state == ST_IDLE || state == ST_DONE);
        load_tc     = (load_cnt == 4'd0);
        done_seen   = (state == ST_RUN) && solver_done_in && (cycle_cnt != '0);
        timeout_hit = (state == ST_RUN) && !done_seen &&
                      (cycle_cnt == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
        finish      = done_seen || timeout_hit;
    end

    always_comb begin
        all_nz = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            if (solver_board_in[i*4 +: 4] == 4'd0) begin
                all_nz = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        busy_out         = 1'b0;
        solver_reset_out = 1'b0;
        case (state)
            ST_IDLE: begin
                solver_reset_out = 1'b1;
                if (start_in) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                solver_reset_out = 1'b1;
                busy_out         = 1'b1;
                if (load_tc) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy_out = 1'b1;
                if (finish) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start_in) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            solver_board_out <= '0;
            board_out        <= '0;
            cycles_out       <= '0;
            cycle_cnt        <= '0;
            load_cnt         <= '0;
            solved_out       <= 1'b0;
            timeout_out      <= 1'b0;
            result_valid_out <= 1'b0;
        end else begin
            result_valid_out <= finish;
            if (start_ok) begin
                solver_board_out <= board_in;
                cycle_cnt        <= '0;
                load_cnt         <= 4'(RESET_CYCLES - 1);
                solved_out       <= 1'b0;
                timeout_out      <= 1'b0;
            end else if (state == ST_LOAD) begin
                if (!load_tc) load_cnt <= load_cnt - 4'd1;
            end else if (state == ST_RUN) begin
                if (finish) begin
                    board_out   <= solver_board_in;
                    cycles_out  <= cycle_cnt;
                    solved_out  <= done_seen && all_nz;
                    timeout_out <= timeout_hit;
                end else if (cycle_cnt != '1) begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/soduku_solve_controller.md
SODUKU_SOLVE_CONTROLLER -- requirements
Module: soduku_solve_controller

Interface
REQ-001 Parameter GRID_SIZE, default 9: board side length; board width is 4*GRID_SIZE*GRID_SIZE bits (324).
REQ-002 Parameter RESET_CYCLES, default 2: number of cycles the solver is held in reset before each run; legal range 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: maximum RUN cycles before the run is abandoned.
REQ-004 Parameter COUNT_WIDTH, default 32: width of the cycle counter and cycles_out.
REQ-005 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n_in  input  1  asynchronous, active-low reset.
REQ-007 start_in  input  1  request to solve board_in; sampled on the rising edge.
REQ-008 board_in  input  324  unsolved board, 4-bit BCD per cell, 0 = empty; row 0 / col 0 in bits [323:320], row-major.
REQ-009 solver_reset_out  output  1  active-high reset to the solver datapath.
REQ-010 solver_board_out  output  324  board presented to the solver.
REQ-011 solver_board_in  input  324  solver board output, same packing as board_in.
REQ-012 solver_done_in  input  1  solver completion flag.
REQ-013 busy_out  output  1  high in LOAD and RUN.
REQ-014 result_valid_out  output  1  one-cycle pulse when a run ends, whether by done or by timeout.
REQ-015 solved_out  output  1  last run ended on done with no zero cell in board_out.
REQ-016 timeout_out  output  1  last run ended by timeout.
REQ-017 board_out  output  324  captured result board.
REQ-018 cycles_out  output  COUNT_WIDTH  RUN cycles consumed by the last run.

Function
REQ-019 FSM states are IDLE, LOAD, RUN and DONE.
REQ-020 IDLE/DONE with start_in=1: board_in is latched into solver_board_out, the counters clear, and the FSM goes to LOAD; start_in is ignored in LOAD and RUN.
REQ-021 LOAD: solver_reset_out=1 for exactly RESET_CYCLES cycles, then the FSM goes to RUN; solver_board_out is stable from LOAD entry to the next start.
REQ-022 RUN: solver_reset_out=0 and the cycle counter increments by 1 per cycle, saturating at all-ones.
REQ-023 RUN with solver_done_in=1: board_out captures solver_board_in on that edge, cycles_out is set to the counter value, and the FSM goes to DONE.
REQ-024 solved_out is set on that capture iff all 81 nibbles of solver_board_in are nonzero; timeout_out is cleared.
REQ-025 RUN with counter == TIMEOUT_CYCLES-1 and solver_done_in=0: the same capture occurs with timeout_out=1 and solved_out=0, then the FSM goes to DONE.
REQ-026 Simultaneous done and timeout edge: done wins, so timeout_out=0.
REQ-027 solver_done_in is ignored in RUN for the first cycle after LOAD, so a stale done cannot end the run.
REQ-028 result_valid_out is high for exactly the first cycle in DONE.
REQ-029 DONE holds board_out, cycles_out, solved_out and timeout_out until the next accepted start; a new start clears solved_out and timeout_out on acceptance.
REQ-030 DONE with start_in=1 re-enters LOAD directly, with no IDLE cycle.
REQ-031 solver_done_in is ignored in IDLE, LOAD and DONE.

Reset
REQ-032 reset_n_in=0 asynchronously forces IDLE with every output at 0 and all counters at 0, except solver_reset_out=1.
REQ-033 In IDLE, solver_reset_out stays at 1.
REQ-034 A reset asserted mid-LOAD or mid-RUN abandons the run and produces no result_valid_out pulse.
REQ-035 The first start is accepted on the first rising edge after reset_n_in deasserts.

Verification
REQ-036 Start with an 80-given board; the solver asserts done 5 cycles into RUN -> solver_reset_out high for 2 cycles, then result_valid_out for 1 cycle, cycles_out=5, solved_out=1, timeout_out=0, board_out equals solver_board_in.
REQ-037 TIMEOUT_CYCLES=50, done never asserted -> result_valid_out at RUN cycle 50, cycles_out=49, timeout_out=1, solved_out=0.
REQ-038 Done asserted while solver_board_in has a zero cell -> solved_out=0, timeout_out=0.
REQ-039 Done and the timeout edge on the same cycle -> timeout_out=0.
REQ-040 start_in pulsed during RUN -> no effect; done held high through LOAD and RUN cycle 0 -> run not ended early.
REQ-041 reset_n_in pulsed low mid-RUN -> immediately IDLE, busy_out=0, solver_reset_out=1, no result pulse; a subsequent start completes normally.
